// File: rtl/game_flow_controller.sv
// Race flow sequencer: menu -> countdown -> race -> finished -> menu.
// Owns movement gating, position clears, the winner latch and the screen select.
//
// state     | meaning
// MENU      | idle; waits for start_btn
// COUNTDOWN | counting down before the race; movement gated
// RACE      | players may advance; watching for finishers
// FINISHED  | winner shown for a fixed hold time
module game_flow_controller #(
    parameter int unsigned MAX_POS               = 109,
    parameter int unsigned COUNTDOWN_STEP_CYCLES = 12000000,
    parameter int unsigned COUNTDOWN_STEPS       = 3,
    parameter int unsigned FINISH_HOLD_CYCLES    = 60000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic [6:0] green_cur_pos,
    input  logic [6:0] red_cur_pos,
    input  logic [6:0] blue_cur_pos,
    input  logic [6:0] yellow_cur_pos,
    output logic       is_in_menu,
    output logic       race_enable,
    output logic       positions_clear,
    output logic [1:0] current_screen,
    output logic [1:0] countdown_value,
    output logic [3:0] winner
);

    localparam int unsigned STEP_W = $clog2(COUNTDOWN_STEP_CYCLES > 1 ? COUNTDOWN_STEP_CYCLES : 2);
    localparam int unsigned HOLD_W = $clog2(FINISH_HOLD_CYCLES > 1 ? FINISH_HOLD_CYCLES : 2);

    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(COUNTDOWN_STEP_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(FINISH_HOLD_CYCLES - 1);
    localparam logic [6:0]        FINISH_POS = 7'(MAX_POS);
    localparam logic [1:0]        CD_START   = 2'(COUNTDOWN_STEPS);

    typedef enum logic [1:0] {
        MENU      = 2'd0,
        COUNTDOWN = 2'd1,
        RACE      = 2'd2,
        FINISHED  = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [STEP_W-1:0]  step_cnt, step_cnt_n;
    logic [HOLD_W-1:0]  hold_cnt, hold_cnt_n;
    logic [1:0]         countdown_n;
    logic [3:0]         winner_n;
    logic               clear_n;
    logic [3:0]         finishers;

    assign finishers = {yellow_cur_pos >= FINISH_POS,
                        blue_cur_pos   >= FINISH_POS,
                        red_cur_pos    >= FINISH_POS,
                        green_cur_pos  >= FINISH_POS};

    always_comb begin
        state_n     = state;
        step_cnt_n  = step_cnt;
        hold_cnt_n  = hold_cnt;
        countdown_n = countdown_value;
        winner_n    = winner;
        clear_n     = 1'b0;
        case (state)
            MENU: begin
                if (start_btn) begin
                    state_n     = COUNTDOWN;
                    clear_n     = 1'b1;
                    countdown_n = CD_START;
                    step_cnt_n  = '0;
                    winner_n    = 4'b0000;
                end
            end
            COUNTDOWN: begin
                if (step_cnt == STEP_LAST) begin
                    step_cnt_n = '0;
                    if (countdown_value == 2'd1) begin
                        state_n     = RACE;
                        countdown_n = 2'd0;
                    end else begin
                        countdown_n = countdown_value - 2'd1;
                    end
                end else begin
                    step_cnt_n = step_cnt + 1'b1;
                end
            end
            RACE: begin
                if (|finishers) begin
                    state_n    = FINISHED;
                    winner_n   = finishers;
                    hold_cnt_n = '0;
                end
            end
            FINISHED: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_n    = MENU;
                    clear_n    = 1'b1;
                    hold_cnt_n = '0;
                end else begin
                    hold_cnt_n = hold_cnt + 1'b1;
                end
            end
            default: state_n = MENU;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= MENU;
            step_cnt        <= '0;
            hold_cnt        <= '0;
            countdown_value <= 2'd0;
            winner          <= 4'b0000;
            positions_clear <= 1'b0;
            is_in_menu      <= 1'b1;
            race_enable     <= 1'b0;
            current_screen  <= 2'b00;
        end else begin
            state           <= state_n;
            step_cnt        <= step_cnt_n;
            hold_cnt        <= hold_cnt_n;
            countdown_value <= countdown_n;
            winner          <= winner_n;
            positions_clear <= clear_n;
            is_in_menu      <= (state_n == MENU);
            race_enable     <= (state_n == RACE);
            case (state_n)
                MENU:      current_screen <= 2'b00;
                RACE:      current_screen <= 2'b01;
                FINISHED:  current_screen <= 2'b10;
                default:   current_screen <= 2'b11;
            endcase
        end
    end

endmodule
